// File: rtl/square_wave_gen.sv
// Programmable square-wave generator with shadowed, period-aligned reconfiguration.
// Optional build macro SQUARE_GEN_BURST_EN adds a finite burst mode (cfg_burst / burst_done).
module square_wave_gen #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_invert,
    output logic             sig_out,
    output logic             period_tick
`ifdef SQUARE_GEN_BURST_EN
    ,
    input  logic [15:0]      cfg_burst,
    output logic             burst_done
`endif
);

    localparam logic [CNT_W-1:0] DEF_PER_C  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_PERIOD / 2);
    localparam logic [CNT_W-1:0] MIN_PER_C  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C     = CNT_W'(0);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] r_high_act;
    logic             r_inv_act;
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_high_sh;
    logic             r_inv_sh;
    logic             r_pending;
    logic             r_sig_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_per_clamped;
    logic             w_run;
    logic             w_last;
    logic             w_capture;
    logic             w_apply_sh;
    logic             w_apply_new;

`ifdef SQUARE_GEN_BURST_EN
    logic [15:0]      r_burst_sh;
    logic [15:0]      r_burst_act;
    logic [15:0]      r_burst_cnt;
    logic             r_stopped;
    logic             r_burst_done;
    logic             w_burst_end;
`endif

    // Control decode: run qualification, period boundary, capture and apply strobes.
    always_comb begin
        w_per_clamped = (cfg_period < MIN_PER_C) ? MIN_PER_C : cfg_period;
`ifdef SQUARE_GEN_BURST_EN
        w_run         = en & ~r_stopped;
`else
        w_run         = en;
`endif
        w_last        = (r_cnt == (r_per_act - ONE_C));
        w_capture     = cfg_valid & ~r_pending;
        // Idle captures bypass the shadow so they take effect on the very next cycle.
        w_apply_new   = w_capture & ~w_run;
        w_apply_sh    = r_pending & (~w_run | w_last);
`ifdef SQUARE_GEN_BURST_EN
        w_burst_end   = w_run & w_last & (r_burst_act != 16'd0) &
                        (r_burst_cnt == (r_burst_act - 16'd1));
`endif
    end

    // Shadow and active configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_act  <= DEF_PER_C;
            r_high_act <= DEF_HIGH_C;
            r_inv_act  <= 1'b0;
            r_per_sh   <= DEF_PER_C;
            r_high_sh  <= DEF_HIGH_C;
            r_inv_sh   <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (w_apply_new) begin
                r_per_act  <= w_per_clamped;
                r_high_act <= cfg_high;
                r_inv_act  <= cfg_invert;
            end else if (w_apply_sh) begin
                r_per_act  <= r_per_sh;
                r_high_act <= r_high_sh;
                r_inv_act  <= r_inv_sh;
            end
            if (w_capture & w_run) begin
                r_per_sh  <= w_per_clamped;
                r_high_sh <= cfg_high;
                r_inv_sh  <= cfg_invert;
                r_pending <= 1'b1;
            end else if (w_apply_sh) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Period counter and registered waveform outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= ZERO_C;
            r_sig_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_run) begin
            r_cnt     <= w_last ? ZERO_C : (r_cnt + ONE_C);
            r_sig_out <= (r_cnt < r_high_act) ^ r_inv_act;
            r_tick    <= w_last;
        end else begin
            r_cnt     <= ZERO_C;
            r_sig_out <= r_inv_act;
            r_tick    <= 1'b0;
        end
    end

`ifdef SQUARE_GEN_BURST_EN
    // Burst length tracking: stop after burst_act periods until en is cycled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_sh   <= 16'd0;
            r_burst_act  <= 16'd0;
            r_burst_cnt  <= 16'd0;
            r_stopped    <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            if (w_apply_new) begin
                r_burst_act <= cfg_burst;
            end else if (w_apply_sh) begin
                r_burst_act <= r_burst_sh;
            end
            if (w_capture & w_run) begin
                r_burst_sh <= cfg_burst;
            end
            if (!en) begin
                r_stopped   <= 1'b0;
                r_burst_cnt <= 16'd0;
            end else if (w_burst_end) begin
                r_stopped   <= 1'b1;
                r_burst_cnt <= 16'd0;
            end else if (w_run & w_last & (r_burst_act != 16'd0)) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
            r_burst_done <= w_burst_end;
        end
    end

    assign burst_done = r_burst_done;
`endif

    assign cfg_ready   = ~r_pending;
    assign sig_out     = r_sig_out;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed self-checking bench for square_wave_gen (default parameters).
// Burst checks are included only when SQUARE_GEN_BURST_EN is defined.
module tb_square_wave_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        cfg_invert;
    logic        sig_out;
    logic        period_tick;
`ifdef SQUARE_GEN_BURST_EN
    logic [15:0] cfg_burst;
    logic        burst_done;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] per;
        logic [15:0] high;
        logic        inv;
        int          exp_per;
        logic [31:0] exp_pat;
    } vec_t;

    vec_t vecs[7];

    square_wave_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_invert  (cfg_invert),
        .sig_out     (sig_out),
        .period_tick (period_tick)
`ifdef SQUARE_GEN_BURST_EN
        ,
        .cfg_burst   (cfg_burst),
        .burst_done  (burst_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [15:0] p, input logic [15:0] h, input logic inv);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_high   = h;
        cfg_invert = inv;
    endtask

    initial begin
        // {period, high, invert, effective period, sig_out pattern per period position}
        vecs[0] = '{16'd10, 16'd3,  1'b0, 10, 32'h0000_0007};
        vecs[1] = '{16'd1,  16'd1,  1'b0, 2,  32'h0000_0001};
        vecs[2] = '{16'd10, 16'd0,  1'b0, 10, 32'h0000_0000};
        vecs[3] = '{16'd10, 16'd20, 1'b0, 10, 32'h0000_03FF};
        vecs[4] = '{16'd10, 16'd3,  1'b1, 10, 32'h0000_03F8};
        vecs[5] = '{16'd0,  16'd1,  1'b1, 2,  32'h0000_0002};
        vecs[6] = '{16'd5,  16'd5,  1'b0, 5,  32'h0000_001F};

        cfg_period = 16'd0;
        cfg_high   = 16'd0;
        cfg_invert = 1'b0;
`ifdef SQUARE_GEN_BURST_EN
        cfg_burst  = 16'd0;
`endif

        // Reset state and default 1024-cycle / 50% waveform
        do_reset();
        chk("rst_sig", sig_out, 1'b0);
        chk("rst_tick", period_tick, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        en = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            step();
            chk("def_sig", sig_out, (k % 1024) < 512);
            chk("def_tick", period_tick, (k % 1024) == 1023);
        end

        // Mid-period reconfiguration at cnt=100; a second offer while busy is ignored
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 1054; k++) begin
            if (k == 100) offer(16'd10, 16'd3, 1'b0);
            else if (k == 200) offer(16'd4, 16'd1, 1'b0);
            else cfg_valid = 1'b0;
            step();
            if (k < 1024) begin
                chk("rcfg_old_sig", sig_out, k < 512);
                chk("rcfg_old_tick", period_tick, k == 1023);
                chk("rcfg_ready", cfg_ready, !(k >= 100 && k < 1023));
            end else begin
                chk("rcfg_new_sig", sig_out, ((k - 1024) % 10) < 3);
                chk("rcfg_new_tick", period_tick, ((k - 1024) % 10) == 9);
                chk("rcfg_new_ready", cfg_ready, 1'b1);
            end
        end
        cfg_valid = 1'b0;

        // Reset at cnt=300 with a pending shadow: shadow must be discarded
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            if (k == 100) offer(16'd10, 16'd3, 1'b0);
            else if (k == 300) begin
                rst = 1'b1;
                offer(16'd4, 16'd1, 1'b1);
            end else cfg_valid = 1'b0;
            step();
            if (k == 150) chk("mrst_pending", cfg_ready, 1'b0);
        end
        chk("mrst_sig", sig_out, 1'b0);
        chk("mrst_tick", period_tick, 1'b0);
        chk("mrst_ready", cfg_ready, 1'b1);
        rst       = 1'b0;
        cfg_valid = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            chk("mrst_def_sig", sig_out, 1'b1);
            chk("mrst_def_tick", period_tick, 1'b0);
        end

        // Table: idle capture applies next cycle, idle level, then two full periods
        for (int i = 0; i < 7; i++) begin
            en = 1'b0;
            offer(vecs[i].per, vecs[i].high, vecs[i].inv);
            step();
            cfg_valid = 1'b0;
            step();
            chk("vec_idle_next", sig_out, vecs[i].inv);
            chk("vec_idle_ready", cfg_ready, 1'b1);
            step();
            chk("vec_idle_hold", sig_out, vecs[i].inv);
            en = 1'b1;
            for (int k = 0; k < 2 * vecs[i].exp_per; k++) begin
                step();
                chk("vec_sig", sig_out, vecs[i].exp_pat[k % vecs[i].exp_per]);
                chk("vec_tick", period_tick, (k % vecs[i].exp_per) == (vecs[i].exp_per - 1));
            end
        end
        en = 1'b0;
        step();

`ifdef SQUARE_GEN_BURST_EN
        // Burst of three 4-cycle periods, then idle until en is cycled
        cfg_burst = 16'd3;
        offer(16'd4, 16'd2, 1'b0);
        step();
        cfg_valid = 1'b0;
        step();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bst_sig", sig_out, (k < 12) && ((k % 4) < 2));
            chk("bst_tick", period_tick, (k < 12) && ((k % 4) == 3));
            chk("bst_done", burst_done, k == 11);
        end
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        step();
        chk("bst_restart", sig_out, 1'b1);
        en = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
